// File: rtl/pattern_detector_pkg.sv
// Shared defaults and types for the serial pattern detector.
package pattern_detector_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_OVERLAP = 1;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // Bits needed to hold a fill count of 0..w inclusive.
    function automatic int unsigned fill_w(int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/pattern_history.sv
// Serial history shift register with a saturating fill counter.
module pattern_history
    import pattern_detector_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clear,
    input  logic             data,
    output logic [WIDTH-1:0] hist_shifted,
    output logic             full_shifted,
    output logic             armed
);

    localparam int unsigned       FW   = fill_w(WIDTH);
    localparam logic [FW-1:0]     FULL = FW'(WIDTH);

    logic [WIDTH-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d, fill_inc;

    // The shifted view is exposed before clear is applied so the parent can
    // decide a match (and hence clear) without a combinational loop.
    always_comb begin
        hist_shifted = {hist_q[WIDTH-2:0], data};
        fill_inc     = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        full_shifted = (fill_inc == FULL);
        hist_d       = hist_q;
        fill_d       = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hist_d = hist_shifted;
            fill_d = fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign armed = (fill_q == FULL);

endmodule

// File: rtl/pattern_detector.sv
// Masked serial pattern detector with overlap mode and saturating match counter.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned OVERLAP_DEF = DEF_OVERLAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_seq,
    input  logic             pat_load,
    input  logic [WIDTH-1:0] pat_val,
    input  logic [WIDTH-1:0] pat_mask,
    input  logic             overlap_in,
    input  logic             cnt_clr,
    output logic             out_seq,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam ovl_mode_e OVL_RST = (OVERLAP_DEF != 0) ? OVL_ON : OVL_OFF;

    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    ovl_mode_e        ovl_q, ovl_d;
    logic             out_seq_q, out_seq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             shift, clear, match;
    logic [WIDTH-1:0] hist_shifted;
    logic             full_shifted;

    pattern_history #(
        .WIDTH(WIDTH)
    ) u_history (
        .clk          (clk),
        .rst          (rst),
        .shift        (shift),
        .clear        (clear),
        .data         (in_seq),
        .hist_shifted (hist_shifted),
        .full_shifted (full_shifted),
        .armed        (armed)
    );

    always_comb begin
        // A load edge swallows any concurrent input bit.
        shift = in_valid & ~pat_load;
        match = shift & full_shifted & (((hist_shifted ^ pat_q) & mask_q) == '0);
        clear = pat_load | (match & (ovl_q == OVL_OFF));

        pat_d     = pat_q;
        mask_d    = mask_q;
        ovl_d     = ovl_q;
        out_seq_d = match;
        cnt_d     = cnt_q;

        if (pat_load) begin
            pat_d  = pat_val;
            mask_d = pat_mask;
            ovl_d  = overlap_in ? OVL_ON : OVL_OFF;
        end

        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= '0;
            mask_q    <= '1;
            ovl_q     <= OVL_RST;
            out_seq_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pat_q     <= pat_d;
            mask_q    <= mask_d;
            ovl_q     <= ovl_d;
            out_seq_q <= out_seq_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_seq     = out_seq_q;
    assign match_count = cnt_q;

endmodule
